// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin arbiter sharing the register-file write port between
//            the ALU (req0) and load (req1) writeback paths. Optional decode
//            bypass ports are enabled by defining WB_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
   parameter int NREG  = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_hold,
   input  logic             req0_valid,
   input  logic [4:0]       req0_rd,
   input  logic [31:0]      req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [4:0]       req1_rd,
   input  logic [31:0]      req1_data,
   output logic             req1_ready,
   output logic             wr_en,
   output logic [4:0]       wr_addr,
   output logic [31:0]      wr_data,
   output logic             err_oob,
`ifdef WB_FWD_EN
   input  logic [4:0]       rs,
   input  logic [4:0]       rt,
   output logic             fwd_a_hit,
   output logic             fwd_b_hit,
   output logic [31:0]      fwd_data,
`endif
   output logic [CNT_W-1:0] drop_cnt
);

   localparam logic [5:0] c_nreg = 6'(NREG);

   logic             r_last_grant;
   logic             r_wr_en;
   logic [4:0]       r_wr_addr;
   logic [31:0]      r_wr_data;
   logic             r_err_oob;
   logic [CNT_W-1:0] r_drop_cnt;

   logic             w_ready0;
   logic             w_ready1;
   logic             w_xfer;
   logic [4:0]       w_sel_rd;
   logic [31:0]      w_sel_data;
   logic             w_sel_oob;
   logic             w_sel_write;

   // Contention goes to whichever requester did not win last time.
   always_comb begin
      w_ready0 = 1'b0;
      w_ready1 = 1'b0;
      if (!rst && !wb_hold) begin
         if (req0_valid && req1_valid) begin
            w_ready0 = r_last_grant;
            w_ready1 = !r_last_grant;
         end else begin
            w_ready0 = req0_valid;
            w_ready1 = req1_valid;
         end
      end
   end

   assign req0_ready = w_ready0;
   assign req1_ready = w_ready1;

   always_comb begin
      w_xfer     = 1'b0;
      w_sel_rd   = req0_rd;
      w_sel_data = req0_data;
      if (req0_valid && w_ready0) begin
         w_xfer = 1'b1;
      end else if (req1_valid && w_ready1) begin
         w_xfer     = 1'b1;
         w_sel_rd   = req1_rd;
         w_sel_data = req1_data;
      end
   end

   assign w_sel_oob   = ({1'b0, w_sel_rd} >= c_nreg);
   assign w_sel_write = w_xfer && (w_sel_rd != 5'd0) && !w_sel_oob;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= 1'b1;
      end else if (req0_valid && w_ready0) begin
         r_last_grant <= 1'b0;
      end else if (req1_valid && w_ready1) begin
         r_last_grant <= 1'b1;
      end
   end

   // Address and data hold their last committed value when nothing is written.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_en    <= 1'b0;
         r_wr_addr  <= 5'd0;
         r_wr_data  <= 32'd0;
         r_err_oob  <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_wr_en   <= w_sel_write;
         r_err_oob <= w_xfer && w_sel_oob;
         if (w_sel_write) begin
            r_wr_addr <= w_sel_rd;
            r_wr_data <= w_sel_data;
         end
         if (w_xfer && w_sel_oob && !(&r_drop_cnt)) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      assert (!(w_ready0 && w_ready1));
   end

   assign wr_en    = r_wr_en;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign err_oob  = r_err_oob;
   assign drop_cnt = r_drop_cnt;

`ifdef WB_FWD_EN
   assign fwd_a_hit = r_wr_en && (r_wr_addr == rs) && (rs != 5'd0);
   assign fwd_b_hit = r_wr_en && (r_wr_addr == rt) && (rt != 5'd0);
   assign fwd_data  = r_wr_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        wb_hold;
   logic        req0_valid;
   logic [4:0]  req0_rd;
   logic [31:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [4:0]  req1_rd;
   logic [31:0] req1_data;
   logic        req1_ready;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        err_oob;
   logic [7:0]  drop_cnt;
`ifdef WB_FWD_EN
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        fwd_a_hit;
   logic        fwd_b_hit;
   logic [31:0] fwd_data;
`endif

   int n_cmp;
   int n_err;

   regfile_wb_arbiter #(.NREG(16), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .wb_hold    (wb_hold),
      .req0_valid (req0_valid),
      .req0_rd    (req0_rd),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_rd    (req1_rd),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .err_oob    (err_oob),
`ifdef WB_FWD_EN
      .rs         (rs),
      .rt         (rt),
      .fwd_a_hit  (fwd_a_hit),
      .fwd_b_hit  (fwd_b_hit),
      .fwd_data   (fwd_data),
`endif
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wb_hold    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      wb_hold    = 1'b0;
      req0_valid = 1'b1;
      req0_rd    = 5'd4;
      req0_data  = 32'h1111_2222;
      req1_valid = 1'b0;
      req1_rd    = 5'd0;
      req1_data  = 32'd0;
      tick();
      #2;
      n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
      tick();
      n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
      n_cmp++; if (wr_addr !== 5'd0) begin n_err++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
      n_cmp++; if (wr_data !== 32'd0) begin n_err++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
      n_cmp++; if (err_oob !== 1'b0) begin n_err++; $display("FAIL reset_err_oob: got %b want 0", err_oob); end
      n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
      req0_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_single();
      req0_valid = 1'b1;
      req0_rd    = 5'd5;
      req0_data  = 32'hDEAD_BEEF;
      #2;
      n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready0: got %b want 1", req0_ready); end
      n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL single_ready1: got %b want 0", req1_ready); end
      tick();
      req0_valid = 1'b0;
      n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en: got %b want 1", wr_en); end
      n_cmp++; if (wr_addr !== 5'd5) begin n_err++; $display("FAIL single_wr_addr: got %0d want 5", wr_addr); end
      n_cmp++; if (wr_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_wr_data: got %h want deadbeef", wr_data); end
      tick();
      n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL single_wr_en_drop: got %b want 0", wr_en); end
      n_cmp++; if (wr_addr !== 5'd5) begin n_err++; $display("FAIL single_addr_hold: got %0d want 5", wr_addr); end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
      do_reset();
      req0_valid = 1'b1; req0_rd = 5'd2; req0_data = 32'hAAAA_0002;
      req1_valid = 1'b1; req1_rd = 5'd3; req1_data = 32'hBBBB_0003;
      for (int i = 0; i < 4; i++) begin
         #2;
         n_cmp++; if (req0_ready !== ((i % 2) == 0)) begin n_err++; $display("FAIL b2b_ready0[%0d]: got %b want %b", i, req0_ready, ((i % 2) == 0)); end
         n_cmp++; if (req1_ready !== ((i % 2) == 1)) begin n_err++; $display("FAIL b2b_ready1[%0d]: got %b want %b", i, req1_ready, ((i % 2) == 1)); end
         tick();
         exp_addr = ((i % 2) == 0) ? 5'd2 : 5'd3;
         exp_data = ((i % 2) == 0) ? 32'hAAAA_0002 : 32'hBBBB_0003;
         n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL b2b_wr_en[%0d]: got %b want 1", i, wr_en); end
         n_cmp++; if (wr_addr !== exp_addr) begin n_err++; $display("FAIL b2b_wr_addr[%0d]: got %0d want %0d", i, wr_addr, exp_addr); end
         n_cmp++; if (wr_data !== exp_data) begin n_err++; $display("FAIL b2b_wr_data[%0d]: got %h want %h", i, wr_data, exp_data); end
      end
      idle_inputs();
      tick();
      n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL b2b_idle_wr_en: got %b want 0", wr_en); end
   endtask

   task automatic test_rd0();
      req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h0000_1234;
      #2;
      n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL rd0_ready1: got %b want 1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rd0_wr_en: got %b want 0", wr_en); end
      n_cmp++; if (err_oob !== 1'b0) begin n_err++; $display("FAIL rd0_err_oob: got %b want 0", err_oob); end
      n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rd0_drop_cnt: got %0d want 0", drop_cnt); end
      n_cmp++; if (wr_addr !== 5'd3) begin n_err++; $display("FAIL rd0_addr_hold: got %0d want 3", wr_addr); end
   endtask

   task automatic test_oob();
      int exp_cnt;
      req0_valid = 1'b1; req0_rd = 5'd20; req0_data = 32'hCAFE_F00D;
      for (int i = 0; i < 300; i++) begin
         tick();
         exp_cnt = (i + 1 > 255) ? 255 : i + 1;
         n_cmp++; if (err_oob !== 1'b1) begin n_err++; $display("FAIL oob_err[%0d]: got %b want 1", i, err_oob); end
         n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL oob_wr_en[%0d]: got %b want 0", i, wr_en); end
         n_cmp++; if (drop_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL oob_cnt[%0d]: got %0d want %0d", i, drop_cnt, exp_cnt); end
      end
      req0_valid = 1'b0;
      tick();
      n_cmp++; if (err_oob !== 1'b0) begin n_err++; $display("FAIL oob_err_clear: got %b want 0", err_oob); end
      n_cmp++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL oob_cnt_hold: got %0d want 255", drop_cnt); end
      n_cmp++; if (wr_addr !== 5'd3) begin n_err++; $display("FAIL oob_addr_hold: got %0d want 3", wr_addr); end
   endtask

   task automatic test_hold_and_reset();
      wb_hold = 1'b1;
      req0_valid = 1'b1; req0_rd = 5'd9;  req0_data = 32'h0000_0009;
      req1_valid = 1'b1; req1_rd = 5'd10; req1_data = 32'h0000_000A;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 00", i, {req0_ready, req1_ready}); end
         tick();
         n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL hold_wr_en[%0d]: got %b want 0", i, wr_en); end
      end
      // last winner was req0, so req1 takes the first grant after release
      wb_hold = 1'b0;
      #2;
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL release_ready: got %b want 01", {req0_ready, req1_ready}); end
      tick();
      n_cmp++; if ((wr_en !== 1'b1) || (wr_addr !== 5'd10)) begin n_err++; $display("FAIL release_write: got en=%b addr=%0d want en=1 addr=10", wr_en, wr_addr); end
      tick();
      wb_hold = 1'b1;
      #2;
      n_cmp++; if ((wr_en !== 1'b1) || (wr_addr !== 5'd9)) begin n_err++; $display("FAIL hold_inflight: got en=%b addr=%0d want en=1 addr=9", wr_en, wr_addr); end
      tick();
      n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL hold_after_inflight: got %b want 0", wr_en); end
      wb_hold = 1'b0;
      tick();
      n_cmp++; if ((wr_en !== 1'b1) || (wr_addr !== 5'd10)) begin n_err++; $display("FAIL prereset_write: got en=%b addr=%0d want en=1 addr=10", wr_en, wr_addr); end
      rst = 1'b1;
      #2;
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b want 00", {req0_ready, req1_ready}); end
      tick();
      n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
      n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
      n_cmp++; if (wr_addr !== 5'd0) begin n_err++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
      rst = 1'b0;
      idle_inputs();
      tick();
   endtask

`ifdef WB_FWD_EN
   task automatic test_fwd();
      req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h5A5A_0707;
      rs = 5'd0; rt = 5'd0;
      tick();
      req0_valid = 1'b0;
      rs = 5'd7; rt = 5'd8;
      #1;
      n_cmp++; if (fwd_a_hit !== 1'b1) begin n_err++; $display("FAIL fwd_a_hit: got %b want 1", fwd_a_hit); end
      n_cmp++; if (fwd_b_hit !== 1'b0) begin n_err++; $display("FAIL fwd_b_hit: got %b want 0", fwd_b_hit); end
      n_cmp++; if (fwd_data !== 32'h5A5A_0707) begin n_err++; $display("FAIL fwd_data: got %h want 5a5a0707", fwd_data); end
      req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'h0000_0BAD;
      tick();
      req0_valid = 1'b0;
      rs = 5'd0; rt = 5'd7;
      #1;
      n_cmp++; if (fwd_a_hit !== 1'b0) begin n_err++; $display("FAIL fwd_a_rd0: got %b want 0", fwd_a_hit); end
      n_cmp++; if (fwd_b_hit !== 1'b0) begin n_err++; $display("FAIL fwd_b_rd0: got %b want 0", fwd_b_hit); end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_err = 0;
`ifdef WB_FWD_EN
      rs = 5'd0;
      rt = 5'd0;
`endif
      test_reset();
      test_single();
      test_back_to_back();
      test_rd0();
      test_oob();
      test_hold_and_reset();
`ifdef WB_FWD_EN
      test_fwd();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
